// File: rtl/gpio_pwm_channel_if.sv
// Register-side and pin-side signals of one PWM channel. The register file
// drives the master side and the channel implements the slave side.
interface gpio_pwm_channel_if #(
  parameter int CNT_WIDTH   = 16,
  parameter int PRESC_WIDTH = 16
);
  logic                   enable;
  logic [PRESC_WIDTH-1:0] prescaler;
  logic [CNT_WIDTH-1:0]   period;
  logic [CNT_WIDTH-1:0]   duty;
  logic                   load;
  logic                   pwm_out;
  logic                   period_tick;
  logic                   pending;

  modport master (
    output enable, prescaler, period, duty, load,
    input  pwm_out, period_tick, pending
  );

  modport slave (
    input  enable, prescaler, period, duty, load,
    output pwm_out, period_tick, pending
  );
endinterface

// File: rtl/gpio_pwm_channel.sv
// Per-pin PWM generator feeding the GPIO alternate-function mux. Period and
// duty pass through a shadow stage and only take effect at a period boundary.
module gpio_pwm_channel #(
  parameter int CNT_WIDTH   = 16,
  parameter int PRESC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  gpio_pwm_channel_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state;
  logic [0:0]             state_next;
  logic [PRESC_WIDTH-1:0] pre_cnt;
  logic [PRESC_WIDTH-1:0] pre_cnt_next;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [CNT_WIDTH-1:0]   act_period;
  logic [CNT_WIDTH-1:0]   act_duty;
  logic [CNT_WIDTH-1:0]   sh_period;
  logic [CNT_WIDTH-1:0]   sh_duty;
  logic [CNT_WIDTH-1:0]   period_next;
  logic [CNT_WIDTH-1:0]   duty_next;
  logic [CNT_WIDTH-1:0]   sh_period_next;
  logic [CNT_WIDTH-1:0]   sh_duty_next;
  logic                   pending_q;
  logic                   pending_next;
  logic                   pwm_q;
  logic                   pwm_next;
  logic                   tick_q;
  logic                   tick_next;
  logic                   step;
  logic                   wrap;

  always_comb begin
    state_next     = state;
    pre_cnt_next   = pre_cnt;
    cnt_next       = cnt;
    period_next    = act_period;
    duty_next      = act_duty;
    sh_period_next = sh_period;
    sh_duty_next   = sh_duty;
    pending_next   = pending_q;
    step           = 1'b0;
    wrap           = 1'b0;

    if (!bus.enable) begin
      // Idle channel: nothing to protect, so new values go live at once
      state_next   = ST_IDLE;
      pre_cnt_next = '0;
      cnt_next     = '0;
      if (bus.load) begin
        period_next    = bus.period;
        duty_next      = bus.duty;
        sh_period_next = bus.period;
        sh_duty_next   = bus.duty;
        pending_next   = 1'b0;
      end else if (pending_q) begin
        period_next  = sh_period;
        duty_next    = sh_duty;
        pending_next = 1'b0;
      end
    end else begin
      if (state == ST_IDLE) begin
        // First enabled edge opens a fresh period at count zero
        state_next   = ST_RUN;
        pre_cnt_next = '0;
        cnt_next     = '0;
      end else begin
        step = (pre_cnt >= bus.prescaler);
        if (step) begin
          pre_cnt_next = '0;
          wrap         = (cnt >= act_period);
          cnt_next     = wrap ? '0 : cnt + CNT_WIDTH'(1);
        end else begin
          pre_cnt_next = pre_cnt + PRESC_WIDTH'(1);
        end
      end

      if (bus.load) begin
        sh_period_next = bus.period;
        sh_duty_next   = bus.duty;
      end

      // A load landing on the wrap edge bypasses the shadow stage entirely
      if (wrap && bus.load) begin
        period_next  = bus.period;
        duty_next    = bus.duty;
        pending_next = 1'b0;
      end else if (wrap && pending_q) begin
        period_next  = sh_period;
        duty_next    = sh_duty;
        pending_next = 1'b0;
      end else if (bus.load) begin
        pending_next = 1'b1;
      end
    end

    tick_next = wrap;
    pwm_next  = bus.enable && (cnt_next < duty_next);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      pre_cnt    <= '0;
      cnt        <= '0;
      act_period <= '0;
      act_duty   <= '0;
      sh_period  <= '0;
      sh_duty    <= '0;
      pending_q  <= 1'b0;
      pwm_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state      <= state_next;
      pre_cnt    <= pre_cnt_next;
      cnt        <= cnt_next;
      act_period <= period_next;
      act_duty   <= duty_next;
      sh_period  <= sh_period_next;
      sh_duty    <= sh_duty_next;
      pending_q  <= pending_next;
      pwm_q      <= pwm_next;
      tick_q     <= tick_next;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_tick = tick_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_gpio_pwm_channel.sv
// Bench for gpio_pwm_channel: a clock-position model of the waveform is
// compared every cycle, and windowed high/tick counts pin both DUT and model.
module tb_gpio_pwm_channel;
  localparam int CW = 16;
  localparam int PW = 16;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  bit   cmp_en = 1'b0;
  int   total  = 0;
  int   passed = 0;

  gpio_pwm_channel_if #(.CNT_WIDTH(CW), .PRESC_WIDTH(PW)) bus();

  gpio_pwm_channel #(.CNT_WIDTH(CW), .PRESC_WIDTH(PW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model state: position in clocks since the current period began
  longint m_pos   = 0;
  longint m_per   = 0;
  longint m_duty  = 0;
  longint m_sper  = 0;
  longint m_sduty = 0;
  bit     m_run   = 1'b0;
  bit     m_pend  = 1'b0;
  logic   m_pwm   = 1'b0;
  logic   m_tick  = 1'b0;

  function automatic longint high_clocks(input longint per, input longint dty,
                                         input longint presc);
    longint d;
    d = (dty > per + 1) ? per + 1 : dty;
    return d * (presc + 1);
  endfunction

  always @(posedge clk or negedge resetn) begin : model_proc
    longint n_pos, n_per, n_duty, n_sper, n_sduty, len, presc;
    bit     n_run, n_pend, n_tick, n_pwm, wrap;
    if (!resetn) begin
      m_pos <= 0; m_per <= 0; m_duty <= 0; m_sper <= 0; m_sduty <= 0;
      m_run <= 1'b0; m_pend <= 1'b0; m_pwm <= 1'b0; m_tick <= 1'b0;
    end else begin
      n_pos = m_pos; n_per = m_per; n_duty = m_duty;
      n_sper = m_sper; n_sduty = m_sduty;
      n_run = m_run; n_pend = m_pend; n_tick = 1'b0; n_pwm = 1'b0; wrap = 1'b0;
      presc = longint'(bus.prescaler);
      if (!bus.enable) begin
        n_run = 1'b0;
        n_pos = 0;
        if (bus.load) begin
          n_per = longint'(bus.period); n_duty = longint'(bus.duty);
          n_sper = n_per; n_sduty = n_duty; n_pend = 1'b0;
        end else if (m_pend) begin
          n_per = m_sper; n_duty = m_sduty; n_pend = 1'b0;
        end
      end else begin
        if (!m_run) begin
          n_run = 1'b1;
          n_pos = 0;
        end else begin
          len = (m_per + 1) * (presc + 1);
          if (m_pos + 1 >= len) begin
            wrap = 1'b1; n_pos = 0; n_tick = 1'b1;
          end else begin
            n_pos = m_pos + 1;
          end
        end
        if (wrap && bus.load) begin
          n_per = longint'(bus.period); n_duty = longint'(bus.duty); n_pend = 1'b0;
        end else if (wrap && m_pend) begin
          n_per = m_sper; n_duty = m_sduty; n_pend = 1'b0;
        end else if (bus.load) begin
          n_sper = longint'(bus.period); n_sduty = longint'(bus.duty); n_pend = 1'b1;
        end
        n_pwm = (n_pos < high_clocks(n_per, n_duty, presc));
      end
      m_pos <= n_pos; m_per <= n_per; m_duty <= n_duty;
      m_sper <= n_sper; m_sduty <= n_sduty;
      m_run <= n_run; m_pend <= n_pend; m_pwm <= n_pwm; m_tick <= n_tick;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cyc_pwm_out", int'(bus.pwm_out), int'(m_pwm));
      check_output("cyc_period_tick", int'(bus.period_tick), int'(m_tick));
      check_output("cyc_pending", int'(bus.pending), int'(m_pend));
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; load is a single-cycle strobe
  task automatic apply_stimulus(input logic en, input int presc, input int per,
                                input int dty, input logic ld);
    bus.enable    = en;
    bus.prescaler = PW'(presc);
    bus.period    = CW'(per);
    bus.duty      = CW'(dty);
    bus.load      = ld;
    tick_clk();
    bus.load      = 1'b0;
  endtask

  task automatic start_run(input int presc, input int per, input int dty);
    apply_stimulus(1'b0, presc, per, dty, 1'b1);
    apply_stimulus(1'b1, presc, per, dty, 1'b0);
  endtask

  task automatic check_window(input string name, input int n,
                              input int exp_high, input int exp_ticks);
    int h, t, mh, mt;
    h = 0; t = 0; mh = 0; mt = 0;
    repeat (n) begin
      if (bus.pwm_out) h++;
      if (bus.period_tick) t++;
      if (m_pwm) mh++;
      if (m_tick) mt++;
      tick_clk();
    end
    check_output({name, "_high"}, h, exp_high);
    check_output({name, "_ticks"}, t, exp_ticks);
    check_output({name, "_model_high"}, mh, exp_high);
    check_output({name, "_model_ticks"}, mt, exp_ticks);
  endtask

  task automatic check_idle(input string name);
    check_output({name, "_pwm"}, int'(bus.pwm_out), 0);
    check_output({name, "_tick"}, int'(bus.period_tick), 0);
    check_output({name, "_pending"}, int'(bus.pending), 0);
  endtask

  initial begin
    bus.enable = 1'b0; bus.prescaler = '0; bus.period = '0;
    bus.duty = '0; bus.load = 1'b0;

    repeat (2) tick_clk();
    check_idle("in_reset");
    resetn = 1'b1;
    cmp_en = 1'b1;
    repeat (3) apply_stimulus(1'b0, 0, 0, 0, 1'b0);
    check_idle("after_reset");

    // Basic 3 high / 7 low, tick every 10 clocks
    start_run(0, 9, 3);
    check_window("basic_p0", 10, 3, 0);
    check_window("basic_p1", 10, 3, 1);

    // Prescaler 2: 12-clock period, 6 clocks high
    start_run(2, 3, 2);
    check_window("presc_p0", 12, 6, 0);
    check_window("presc_p1", 12, 6, 1);

    // Shadow load at cnt=5 waits for the wrap
    start_run(0, 9, 3);
    check_window("shadow_head", 5, 3, 0);
    apply_stimulus(1'b1, 0, 4, 4, 1'b1);
    check_output("shadow_pending_set", int'(bus.pending), 1);
    check_window("shadow_tail", 4, 0, 0);
    check_output("shadow_pending_clr", int'(bus.pending), 0);
    check_window("shadow_new0", 5, 4, 1);
    check_window("shadow_new1", 5, 4, 1);

    // Edge duties and zero period
    start_run(0, 9, 0);
    check_window("duty0", 20, 0, 1);
    start_run(0, 9, 15);
    check_window("duty_over", 20, 20, 1);
    start_run(0, 0, 1);
    check_window("period0", 5, 5, 4);

    // Load on the wrap edge goes straight to the active registers
    start_run(0, 9, 3);
    check_window("simul_head", 9, 3, 0);
    apply_stimulus(1'b1, 0, 2, 1, 1'b1);
    check_output("simul_tick", int'(bus.period_tick), 1);
    check_output("simul_pending", int'(bus.pending), 0);
    check_output("simul_pwm", int'(bus.pwm_out), 1);
    check_window("simul_p0", 3, 1, 1);
    check_window("simul_p1", 3, 1, 1);

    // Drop enable at cnt=4, then re-enable for a fresh period
    start_run(0, 9, 3);
    check_window("drop_head", 4, 3, 0);
    apply_stimulus(1'b0, 0, 9, 3, 1'b0);
    check_output("drop_pwm", int'(bus.pwm_out), 0);
    check_output("drop_tick", int'(bus.period_tick), 0);
    apply_stimulus(1'b1, 0, 9, 3, 1'b0);
    check_window("restart_p0", 10, 3, 0);
    check_window("restart_wrap", 1, 1, 1);

    // Asynchronous reset mid-period with pwm high and a pending shadow
    start_run(0, 9, 3);
    apply_stimulus(1'b1, 0, 9, 3, 1'b1);
    check_output("pre_reset_pwm", int'(bus.pwm_out), 1);
    check_output("pre_reset_pending", int'(bus.pending), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_idle("async_reset");
    repeat (2) tick_clk();
    resetn = 1'b1;
    repeat (3) apply_stimulus(1'b0, 0, 9, 3, 1'b0);
    check_idle("post_reset_idle");
    apply_stimulus(1'b1, 0, 9, 3, 1'b0);
    check_output("post_reset_duty0", int'(bus.pwm_out), 0);
    tick_clk();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
